// File: rtl/nibble_serial_addsub_seq.sv
// Multi-nibble add/subtract sequencer. Drives an external 4-bit ripple-carry
// slice one nibble pair per cycle, LSB first, chaining the slice carry-out
// into the next cycle's carry-in, and assembles a 4*NIBBLES-bit result with
// carry-out and signed overflow.
module nibble_serial_addsub_seq #(
  parameter int NIBBLES = 4
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   start,
  input  logic                   sub,
  input  logic [4*NIBBLES-1:0]   op_a,
  input  logic [4*NIBBLES-1:0]   op_b,
  output logic                   busy,
  output logic                   done,
  output logic [4*NIBBLES-1:0]   result,
  output logic                   cout,
  output logic                   ovf,
  output logic [3:0]             nib_a,
  output logic [3:0]             nib_b,
  output logic                   nib_cin,
  input  logic [3:0]             nib_s,
  input  logic                   nib_cout
);

  localparam int W  = 4 * NIBBLES;
  localparam int IW = (NIBBLES > 1) ? $clog2(NIBBLES) : 1;
  localparam logic [IW-1:0] LAST = IW'(NIBBLES - 1);

  typedef enum logic [1:0] {
    S_IDLE,
    S_RUN,
    S_DONE
  } state_t;

  state_t        state;
  state_t        state_nxt;
  logic [IW-1:0] idx;
  logic          carry;
  logic [W-1:0]  a_reg;
  logic [W-1:0]  b_reg;

  // State register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= S_IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Next-state decode; start is only honoured in IDLE.
  always_comb begin
    state_nxt = state;
    unique case (state)
      S_IDLE:  if (start) state_nxt = S_RUN;
      S_RUN:   if (idx == LAST) state_nxt = S_DONE;
      S_DONE:  state_nxt = S_IDLE;
      default: state_nxt = S_IDLE;
    endcase
  end

  // Status outputs and slice drive; the slice sees zeros outside RUN.
  always_comb begin
    busy    = 1'b0;
    done    = 1'b0;
    nib_a   = '0;
    nib_b   = '0;
    nib_cin = 1'b0;
    if (state == S_RUN) begin
      busy    = 1'b1;
      nib_a   = a_reg[4*idx +: 4];
      nib_b   = b_reg[4*idx +: 4];
      nib_cin = carry;
    end
    if (state == S_DONE) begin
      done = 1'b1;
    end
  end

  // Operand capture, per-nibble result assembly and final flags.
  // Subtraction stores ~B and seeds the carry with 1 so the slice computes A+~B+1.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      idx    <= '0;
      carry  <= 1'b0;
      a_reg  <= '0;
      b_reg  <= '0;
      result <= '0;
      cout   <= 1'b0;
      ovf    <= 1'b0;
    end else begin
      unique case (state)
        S_IDLE: begin
          if (start) begin
            a_reg  <= op_a;
            b_reg  <= sub ? ~op_b : op_b;
            carry  <= sub;
            idx    <= '0;
            result <= '0;
          end
        end
        S_RUN: begin
          result[4*idx +: 4] <= nib_s;
          carry              <= nib_cout;
          idx                <= idx + 1'b1;
          if (idx == LAST) begin
            cout <= nib_cout;
            ovf  <= (a_reg[W-1] == b_reg[W-1]) && (nib_s[3] != a_reg[W-1]);
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_nibble_serial_addsub_seq.sv
// Bench for nibble_serial_addsub_seq with NIBBLES=4; models the external
// slice as a plain 4-bit adder and compares against integer arithmetic.
module tb_nibble_serial_addsub_seq;

  localparam int N = 4;
  localparam int W = 16;

  logic         clk = 1'b0;
  logic         rst;
  logic         start;
  logic         sub;
  logic [W-1:0] op_a;
  logic [W-1:0] op_b;
  logic         busy;
  logic         done;
  logic [W-1:0] result;
  logic         cout;
  logic         ovf;
  logic [3:0]   nib_a;
  logic [3:0]   nib_b;
  logic         nib_cin;
  logic [3:0]   nib_s;
  logic         nib_cout;

  int n_vec = 0;
  int n_err = 0;

  nibble_serial_addsub_seq #(.NIBBLES(N)) dut (
    .clk      (clk),
    .rst      (rst),
    .start    (start),
    .sub      (sub),
    .op_a     (op_a),
    .op_b     (op_b),
    .busy     (busy),
    .done     (done),
    .result   (result),
    .cout     (cout),
    .ovf      (ovf),
    .nib_a    (nib_a),
    .nib_b    (nib_b),
    .nib_cin  (nib_cin),
    .nib_s    (nib_s),
    .nib_cout (nib_cout)
  );

  always #5 clk = ~clk;

  // External 4-bit slice.
  assign {nib_cout, nib_s} = {1'b0, nib_a} + {1'b0, nib_b} + {4'b0, nib_cin};

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, want 0x%0h", tag, obs, exp);
    end
  endtask

  // Reference: {ovf, cout, result} from integer arithmetic.
  function automatic logic [17:0] ref_op(input logic [W-1:0] a, input logic [W-1:0] b,
                                         input logic s);
    int sa, sb, r, ua, ub, ur;
    logic c, o;
    logic [W-1:0] res;
    sa  = $signed(a);
    sb  = $signed(b);
    ua  = int'(a);
    ub  = int'(b);
    r   = s ? sa - sb : sa + sb;
    ur  = s ? ua - ub : ua + ub;
    res = ur[W-1:0];
    c   = s ? (ua >= ub) : (ur > 65535);
    o   = (r > 32767) || (r < -32768);
    return {o, c, res};
  endfunction

  // Carry entering nibble k, from the partial sum of the lower 4k bits.
  function automatic logic exp_cin(input logic [W-1:0] a, input logic [W-1:0] b,
                                   input logic s, input int k);
    int m, t;
    logic [W-1:0] be;
    be = s ? ~b : b;
    m  = (1 << (4 * k)) - 1;
    t  = (int'(a) & m) + (int'(be) & m) + int'(s);
    return ((t >> (4 * k)) & 1) != 0;
  endfunction

  task automatic run_op(input logic [W-1:0] a, input logic [W-1:0] b, input logic s,
                        input string tag, input bit inj);
    logic [17:0]  e;
    logic [W-1:0] be;
    int done_cyc;
    e        = ref_op(a, b, s);
    be       = s ? ~b : b;
    done_cyc = 0;
    @(negedge clk);
    op_a  = a;
    op_b  = b;
    sub   = s;
    start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    op_a  = W'($urandom);
    op_b  = W'($urandom);
    sub   = 1'($urandom);
    for (int k = 1; k <= 12; k++) begin
      @(negedge clk);
      if (done) begin
        done_cyc = k;
        break;
      end
      if (k <= N) begin
        check($sformatf("%s.busy%0d", tag, k), busy, 1);
        check($sformatf("%s.nib_a%0d", tag, k), nib_a, a[4*(k-1) +: 4]);
        check($sformatf("%s.nib_b%0d", tag, k), nib_b, be[4*(k-1) +: 4]);
        check($sformatf("%s.nib_cin%0d", tag, k), nib_cin, exp_cin(a, b, s, k - 1));
      end
      if (inj && k == 2) begin
        start = 1'b1;
        op_a  = ~a;
        op_b  = W'($urandom);
        sub   = ~s;
      end
      if (inj && k == 3) start = 1'b0;
    end
    start = 1'b0;
    check($sformatf("%s.done_cycle", tag), done_cyc, N + 1);
    check($sformatf("%s.result", tag), result, e[15:0]);
    check($sformatf("%s.cout", tag), cout, e[16]);
    check($sformatf("%s.ovf", tag), ovf, e[17]);
    check($sformatf("%s.busy_in_done", tag), busy, 0);
    @(negedge clk);
    check($sformatf("%s.done_pulse", tag), done, 0);
    check($sformatf("%s.busy_after", tag), busy, 0);
    check($sformatf("%s.result_hold", tag), result, e[15:0]);
  endtask

  task automatic reset_mid_run();
    int done_seen;
    done_seen = 0;
    @(negedge clk);
    op_a  = 16'h1234;
    op_b  = 16'h4321;
    sub   = 1'b0;
    start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    @(negedge clk);
    @(negedge clk);
    check("rstmid.busy_before", busy, 1);
    rst = 1'b1;
    #1;
    check("rstmid.busy", busy, 0);
    check("rstmid.done", done, 0);
    check("rstmid.result", result, 0);
    check("rstmid.cout", cout, 0);
    check("rstmid.ovf", ovf, 0);
    check("rstmid.nib_a", nib_a, 0);
    check("rstmid.nib_cin", nib_cin, 0);
    @(negedge clk);
    rst = 1'b0;
    for (int k = 0; k < 8; k++) begin
      @(negedge clk);
      if (done) done_seen++;
    end
    check("rstmid.no_done", done_seen, 0);
  endtask

  initial begin
    #200000;
    $display("FAIL timeout: got no finish, want finish");
    $fatal(1, "timeout");
  end

  initial begin
    rst   = 1'b1;
    start = 1'b0;
    sub   = 1'b0;
    op_a  = '0;
    op_b  = '0;
    #12;
    check("rst.busy", busy, 0);
    check("rst.done", done, 0);
    check("rst.result", result, 0);
    check("rst.cout", cout, 0);
    check("rst.ovf", ovf, 0);
    check("rst.nib", {nib_a, nib_b, nib_cin}, 0);
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    check("idle.nib", {nib_a, nib_b, nib_cin}, 0);

    run_op(16'h1234, 16'h0FFF, 1'b0, "add_1234_0fff", 1'b0);
    check("add_1234_0fff.abs", result, 16'h2233);
    run_op(16'hFFFF, 16'h0001, 1'b0, "add_ffff_0001", 1'b0);
    check("add_ffff_0001.abs", {cout, result}, 17'h10000);
    run_op(16'h7FFF, 16'h0001, 1'b0, "add_7fff_0001", 1'b0);
    check("add_7fff_0001.abs", {ovf, cout, result}, 18'h28000);
    run_op(16'h0005, 16'h0007, 1'b1, "sub_0005_0007", 1'b0);
    check("sub_0005_0007.abs", {ovf, cout, result}, 18'h0FFFE);
    run_op(16'h8000, 16'h0001, 1'b1, "sub_8000_0001", 1'b0);
    check("sub_8000_0001.abs", {ovf, cout, result}, 18'h37FFF);
    run_op(16'h1234, 16'h0FFF, 1'b0, "start_in_run", 1'b1);
    check("start_in_run.abs", result, 16'h2233);

    reset_mid_run();
    run_op(16'hA5A5, 16'h5A5B, 1'b0, "after_rst", 1'b0);

    for (int i = 0; i < 40; i++) begin
      run_op(W'($urandom), W'($urandom), 1'($urandom), $sformatf("rnd%0d", i), 1'($urandom));
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
